// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester arbiter for a single synchronous memory port. Requesters A
//   and B are granted combinationally in the cycle they ask. Ties alternate
//   on a last-grant pointer. B may lock the port for a burst of up to
//   MAX_BURST consecutive grants; after that, a waiting A is served.
//   Read data returns one cycle after the grant with a single-cycle valid
//   pulse to the requester that issued the read.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_din        requester A command (held until granted)
//   b_req/b_we/b_addr/b_din/b_lock requester B command, b_lock = burst ownership
//   a_gnt, b_gnt                   same-cycle grant (never both)
//   a_valid/a_dout, b_valid/b_dout read return, dout is 0 when valid is 0
//   mem_en/mem_we/mem_addr/mem_din memory command, all 0 when nothing granted
//   mem_dout                       memory read data, one cycle after command
module mem_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              b_req,
    input  logic [3:0]        a_we,
    input  logic [3:0]        b_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [31:0]       a_din,
    input  logic [31:0]       b_din,
    input  logic              b_lock,
    output logic              a_gnt,
    output logic              b_gnt,
    output logic              a_valid,
    output logic              b_valid,
    output logic [31:0]       a_dout,
    output logic [31:0]       b_dout,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic {IDLE, B_BURST} state_t;

    state_t           state;
    logic             last_b;     // 1: B was granted most recently
    logic [CNT_W-1:0] burst_cnt;
    logic             a_vld_p0;
    logic             b_vld_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v >= CNT_MAX)
            return CNT_MAX;
        return v + 1'b1;
    endfunction

    // Grant decision. Grants are forced low while reset is asserted so a
    // reset arriving mid-cycle also withdraws the memory command.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (state == B_BURST && b_req && b_lock) begin
                // Locked burst: B keeps the port until the counter has
                // saturated and A is actually waiting.
                if (burst_cnt < CNT_MAX || !a_req)
                    b_gnt = 1'b1;
                else
                    a_gnt = 1'b1;
            end else if (a_req && b_req) begin
                a_gnt = last_b;
                b_gnt = !last_b;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        mem_we   = '0;
        mem_addr = '0;
        mem_din  = '0;
        if (a_gnt) begin
            mem_we   = a_we;
            mem_addr = a_addr;
            mem_din  = a_din;
        end else if (b_gnt) begin
            mem_we   = b_we;
            mem_addr = b_addr;
            mem_din  = b_din;
        end
    end

    assign mem_en = a_gnt | b_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_b    <= 1'b1;
            burst_cnt <= '0;
            a_vld_p0  <= 1'b0;
            b_vld_p0  <= 1'b0;
        end else begin
            if (a_gnt || b_gnt)
                last_b <= b_gnt;
            // Only a locked grant to B keeps (or starts) ownership; every
            // other outcome, including A's forced turn, ends the burst.
            if (b_gnt && b_lock) begin
                state     <= B_BURST;
                burst_cnt <= (state == IDLE) ? CNT_W'(1) : sat_inc(burst_cnt);
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
            // stage p0: read grant -> valid aligned with mem_dout
            a_vld_p0 <= a_gnt && (a_we == 4'b0000);
            b_vld_p0 <= b_gnt && (b_we == 4'b0000);
        end
    end

    assign a_valid = a_vld_p0;
    assign b_valid = b_vld_p0;
    assign a_dout  = a_vld_p0 ? mem_dout : 32'h0;
    assign b_dout  = b_vld_p0 ? mem_dout : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A small synchronous memory model
//   returns 32'hC0DE_0000 | addr one cycle after a read command and a filler
//   pattern otherwise. Inputs change on the falling edge; grants and the
//   memory command are sampled 1 ns later, valids 1 ns after the rising edge.
module tb_mem_port_arbiter;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          a_req, b_req, b_lock;
    logic [3:0]    a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [31:0]   a_din, b_din;
    logic          a_gnt, b_gnt, a_valid, b_valid;
    logic [31:0]   a_dout, b_dout;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    int n_checks = 0;
    int n_errors = 0;
    logic exp_a;

    mem_port_arbiter #(.ADDR_W(AW), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .b_req(b_req),
        .a_we(a_we), .b_we(b_we),
        .a_addr(a_addr), .b_addr(b_addr),
        .a_din(a_din), .b_din(b_din),
        .b_lock(b_lock),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_valid(a_valid), .b_valid(b_valid),
        .a_dout(a_dout), .b_dout(b_dout),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        mem_dout <= (mem_en && mem_we == 4'b0000) ? (32'hC0DE_0000 | {20'h0, mem_addr})
                                                  : 32'h5A5A_5A5A;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic set_a(input logic req, input logic [3:0] we, input logic [AW-1:0] addr,
                         input logic [31:0] din);
        a_req = req; a_we = we; a_addr = addr; a_din = din;
    endtask

    task automatic set_b(input logic req, input logic [3:0] we, input logic [AW-1:0] addr,
                         input logic [31:0] din, input logic lock);
        b_req = req; b_we = we; b_addr = addr; b_din = din; b_lock = lock;
    endtask

    task automatic idle_all();
        set_a(1'b0, 4'h0, '0, 32'h0);
        set_b(1'b0, 4'h0, '0, 32'h0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_all();
        mem_dout = 32'h0;

        // Reset: both requesting, nothing may be granted
        @(negedge clk);
        set_a(1'b1, 4'h0, 12'h001, 32'h0);
        set_b(1'b1, 4'h0, 12'h002, 32'h0, 1'b1);
        #1;
        check("rst_a_gnt", 32'(a_gnt), 32'd0);
        check("rst_b_gnt", 32'(b_gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);

        @(negedge clk);
        idle_all();
        rst = 1'b0;

        // Both reading: alternate A,B,A,B starting with A
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_a(1'b1, 4'h0, 12'h001, 32'h0);
            set_b(1'b1, 4'h0, 12'h002, 32'h0, 1'b0);
            #1;
            exp_a = (i % 2 == 0);
            check("tie_a_gnt", 32'(a_gnt), 32'(exp_a));
            check("tie_b_gnt", 32'(b_gnt), 32'(!exp_a));
            check("tie_mem_addr", 32'(mem_addr), exp_a ? 32'h001 : 32'h002);
            @(posedge clk); #1;
            check("tie_a_valid", 32'(a_valid), 32'(exp_a));
            check("tie_b_valid", 32'(b_valid), 32'(!exp_a));
            check("tie_dout", exp_a ? a_dout : b_dout, exp_a ? 32'hC0DE_0001 : 32'hC0DE_0002);
        end
        @(negedge clk);
        idle_all();
        #1;
        check("idle_mem_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        check("idle_a_valid", 32'(a_valid), 32'd0);
        check("idle_b_valid", 32'(b_valid), 32'd0);
        check("idle_a_dout", a_dout, 32'h0);

        // A read alone of 12'h010
        @(negedge clk);
        set_a(1'b1, 4'h0, 12'h010, 32'h0);
        #1;
        check("ard_a_gnt", 32'(a_gnt), 32'd1);
        check("ard_b_gnt", 32'(b_gnt), 32'd0);
        check("ard_mem_en", 32'(mem_en), 32'd1);
        check("ard_mem_addr", 32'(mem_addr), 32'h010);
        check("ard_mem_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        check("ard_a_valid", 32'(a_valid), 32'd1);
        check("ard_a_dout", a_dout, 32'hC0DE_0010);
        check("ard_b_valid", 32'(b_valid), 32'd0);
        @(negedge clk);
        idle_all();
        @(posedge clk); #1;
        check("ard_a_valid_end", 32'(a_valid), 32'd0);
        check("ard_a_dout_end", a_dout, 32'h0);

        // Locked burst: B for 8 cycles, A on cycle 9, IDLE again (B wins cycle 10)
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            set_b(1'b1, 4'h0, 12'h005, 32'h0, 1'b1);
            set_a(c >= 2, 4'h0, 12'h007, 32'h0);
            #1;
            check($sformatf("burst_b_gnt_c%0d", c), 32'(b_gnt), 32'(c <= 8 || c == 10));
            check($sformatf("burst_a_gnt_c%0d", c), 32'(a_gnt), 32'(c == 9));
            @(posedge clk); #1;
            check($sformatf("burst_b_valid_c%0d", c), 32'(b_valid), 32'(c <= 8 || c == 10));
            check($sformatf("burst_a_valid_c%0d", c), 32'(a_valid), 32'(c == 9));
        end
        @(negedge clk);
        idle_all();
        @(posedge clk); #1;

        // Burst of 3, b_lock dropped on cycle 4 with A waiting: A wins
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            set_b(1'b1, 4'h0, 12'h00B, 32'h0, c <= 3);
            set_a(c >= 2, 4'h0, 12'h00A, 32'h0);
            #1;
            check($sformatf("drop_b_gnt_c%0d", c), 32'(b_gnt), 32'(c <= 3));
            check($sformatf("drop_a_gnt_c%0d", c), 32'(a_gnt), 32'(c == 4));
            @(posedge clk); #1;
        end
        check("drop_a_dout", a_dout, 32'hC0DE_000A);
        @(negedge clk);
        idle_all();
        @(posedge clk); #1;

        // B byte write: command passes through, no valid pulse
        @(negedge clk);
        set_b(1'b1, 4'b0011, 12'h0AB, 32'hABAB_ABAB, 1'b0);
        set_a(1'b0, 4'hF, 12'h0CC, 32'h1234_5678);
        #1;
        check("wr_b_gnt", 32'(b_gnt), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'h3);
        check("wr_mem_din", mem_din, 32'hABAB_ABAB);
        check("wr_mem_addr", 32'(mem_addr), 32'h0AB);
        @(posedge clk); #1;
        check("wr_b_valid", 32'(b_valid), 32'd0);
        check("wr_b_dout", b_dout, 32'h0);

        // A read committed, so the pointer now favours B
        @(negedge clk);
        idle_all();
        set_a(1'b1, 4'h0, 12'h030, 32'h0);
        #1;
        check("pre_a_gnt", 32'(a_gnt), 32'd1);
        @(posedge clk); #1;
        check("pre_a_dout", a_dout, 32'hC0DE_0030);

        // A read granted, reset arrives before the capturing edge
        @(negedge clk);
        set_a(1'b1, 4'h0, 12'h020, 32'h0);
        #1;
        check("rr_a_gnt", 32'(a_gnt), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rr_a_gnt_rst", 32'(a_gnt), 32'd0);
        check("rr_mem_en_rst", 32'(mem_en), 32'd0);
        check("rr_a_valid_now", 32'(a_valid), 32'd0);
        @(posedge clk); #1;
        check("rr_a_valid", 32'(a_valid), 32'd0);
        check("rr_a_dout", a_dout, 32'h0);
        @(negedge clk);
        idle_all();
        rst = 1'b0;
        @(posedge clk); #1;
        check("rr_a_valid_after", 32'(a_valid), 32'd0);
        @(negedge clk);
        set_a(1'b1, 4'h0, 12'h001, 32'h0);
        set_b(1'b1, 4'h0, 12'h002, 32'h0, 1'b0);
        #1;
        check("rr_tie_a_gnt", 32'(a_gnt), 32'd1);
        check("rr_tie_b_gnt", 32'(b_gnt), 32'd0);
        @(posedge clk); #1;

        // Reset mid-burst cancels B's pending valid and drops ownership
        @(negedge clk);
        idle_all();
        @(posedge clk); #1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            set_b(1'b1, 4'h0, 12'h006, 32'h0, 1'b1);
            set_a(c >= 2, 4'h0, 12'h008, 32'h0);
            #1;
            check($sformatf("mb_b_gnt_c%0d", c), 32'(b_gnt), 32'd1);
            @(posedge clk); #1;
        end
        check("mb_b_valid_pre", 32'(b_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("mb_b_valid_rst", 32'(b_valid), 32'd0);
        check("mb_b_dout_rst", b_dout, 32'h0);
        check("mb_b_gnt_rst", 32'(b_gnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mb_a_gnt_after", 32'(a_gnt), 32'd1);
        check("mb_b_gnt_after", 32'(b_gnt), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        idle_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the shared memory port.
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum consecutive locked grants to requester B while A waits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have ports a_req, b_req, input, 1, the requester asks for the port this cycle.
REQ-006 SHALL have ports a_we, b_we, input, 4, byte write enables; 4'b0000 means read.
REQ-007 SHALL have ports a_addr, b_addr, input, ADDR_W, word address.
REQ-008 SHALL have ports a_din, b_din, input, 32, byte-replicated write data.
REQ-009 SHALL have port b_lock, input, 1, B requests burst ownership.
REQ-010 SHALL have ports a_gnt, b_gnt, output, 1, the request is accepted this cycle.
REQ-011 SHALL have ports a_valid, b_valid, output, 1, read data is valid on the requester's dout.
REQ-012 SHALL have ports a_dout, b_dout, output, 32, read data returned to the requester.
REQ-013 SHALL have ports mem_en, output, 1; mem_we, output, 4; mem_addr, output, ADDR_W; mem_din, output, 32: the memory command.
REQ-014 SHALL have port mem_dout, input, 32, synchronous memory read data, valid the cycle after the command.

Function
REQ-015 SHALL implement states IDLE and B_BURST, a last-grant pointer (A/B), and a burst counter of width clog2(MAX_BURST)+1.
REQ-016 SHALL compute a_gnt and b_gnt combinationally in the same cycle as the request, and SHALL never assert both in one cycle.
REQ-017 IDLE: with only one request active, SHALL grant it; with both active, SHALL grant the requester that was not granted last; with neither active, SHALL grant none.
REQ-018 SHALL update the last-grant pointer on every grant.
REQ-019 Grant to B with b_lock=1 in IDLE SHALL enter B_BURST with counter=1.
REQ-020 B_BURST with b_req&b_lock and (counter<MAX_BURST or a_req=0) SHALL grant B and increment the counter, saturating at MAX_BURST.
REQ-021 B_BURST with counter==MAX_BURST and a_req=1 SHALL grant A, return to IDLE, and clear the counter.
REQ-022 B_BURST with b_req=0 or b_lock=0 SHALL return to IDLE in that same cycle, clear the counter, and arbitrate per REQ-017.
REQ-023 SHALL set mem_en = a_gnt|b_gnt and drive mem_we/mem_addr/mem_din from the granted requester; when there is no grant, all of them SHALL be 0.
REQ-024 A read granted in cycle N SHALL assert that requester's valid for exactly cycle N+1, with dout = mem_dout; the other requester's valid SHALL stay 0.
REQ-025 A write grant SHALL produce no valid pulse.
REQ-026 dout SHALL be 0 whenever the corresponding valid is 0.
REQ-027 Back-to-back reads SHALL sustain one grant per cycle, with valids pipelined at one-cycle latency.
REQ-028 A requester SHALL hold req, we, addr and din stable until granted; the arbiter stores no request.

Reset
REQ-029 While rst=1, SHALL hold state=IDLE, pointer=B (so A wins the first tie), counter=0, and a_valid=b_valid=0.
REQ-030 Assertion of rst mid-read SHALL cancel the pending valid pulse; assertion mid-burst SHALL drop ownership.
REQ-031 During reset, gnt and mem_* SHALL be 0.

Verification
REQ-032 Bench SHALL cover: release reset, a_req=b_req=1, both reads, for 4 cycles -> grants A,B,A,B; valids one cycle later matching mem_dout.
REQ-033 Bench SHALL cover: a_req read of addr 12'h010 alone -> a_gnt=1, mem_addr=12'h010, mem_we=0; a_valid=1 next cycle only.
REQ-034 Bench SHALL cover: b_req=b_lock=1 held, a_req=1 from cycle 2 -> B granted 8 consecutive cycles, A granted in cycle 9, state IDLE.
REQ-035 Bench SHALL cover: burst of 3 with b_lock dropped in cycle 4 while a_req=1 -> A granted in cycle 4.
REQ-036 Bench SHALL cover: B write with b_we=4'b0011 and b_din=32'hABABABAB -> mem_we=4'b0011, mem_din=32'hABABABAB; no b_valid.
REQ-037 Bench SHALL cover: rst asserted asynchronously the cycle after an A read grant -> a_valid never pulses; first tie after release goes to A.
